// File: rtl/tt_ecp5_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_ecp5_pkg
// Description : Shared defaults and helpers for the ECP5 board-input
//               conditioning block (synchronizers, debounce, reset stretch).
//               Optional feature macro used by the block: TT_INPUT_DEBOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_ecp5_pkg;

    // Default configuration of the conditioning block.
    localparam int c_DEF_WIDTH           = 8;
    localparam int c_DEF_DEBOUNCE_CYCLES = 50000;
    localparam int c_DEF_RST_STRETCH     = 16;

    // Legal parameter ranges.
    localparam int c_DEBOUNCE_MIN = 2;
    localparam int c_DEBOUNCE_MAX = 2 ** 20;

    // Width of a counter that must represent values 0..n-1; never narrower
    // than one bit so degenerate configurations still elaborate.
    function automatic int f_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : tt_ecp5_pkg
`default_nettype wire

// File: rtl/tt_ecp5_input_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_ecp5_input_cond_if
// Description : Board-side / design-side signal bundle of the input
//               conditioning block.
//   pin_in     : raw asynchronous switches/buttons      (board  -> block)
//   btn_rst_n  : raw asynchronous reset button, act-low (board  -> block)
//   ui_in      : conditioned inputs                     (block  -> design)
//   rst_n      : stretched active-low reset             (block  -> design)
//   change_stb : one-cycle pulse per changed ui_in bit  (block  -> design)
//   Modports: slave = conditioning block, master = board/environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_ecp5_input_cond_if
    import tt_ecp5_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
);
    logic [WIDTH-1:0] pin_in;
    logic             btn_rst_n;
    logic [WIDTH-1:0] ui_in;
    logic             rst_n;
    logic [WIDTH-1:0] change_stb;

    modport slave (
        input  pin_in,
        input  btn_rst_n,
        output ui_in,
        output rst_n,
        output change_stb
    );

    modport master (
        output pin_in,
        output btn_rst_n,
        input  ui_in,
        input  rst_n,
        input  change_stb
    );

endinterface : tt_ecp5_input_cond_if
`default_nettype wire

// File: rtl/tt_ecp5_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : tt_ecp5_debounce_bit
// Description : One board input bit: two-flop synchronizer followed by a
//               stability debouncer. A change seen at the synchronizer output
//               must persist for DEBOUNCE_CYCLES consecutive edges before the
//               debounced value follows; shorter glitches are discarded.
//               Macro TT_INPUT_DEBOUNCE_EN: when undefined the debouncer is
//               removed and the debounced value tracks the synchronizer
//               output every cycle.
//   clk, rst : clock and synchronous active-high reset
//   i_pin    : raw asynchronous input bit
//   o_deb    : registered debounced value
//   o_stb    : one-cycle pulse in the cycle o_deb takes a new value
// Revision    : 1.0 - initial release
// ============================================================================
module tt_ecp5_debounce_bit
    import tt_ecp5_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_deb,
    output logic o_stb
);

    logic r_sync1;
    logic r_sync2;
    logic r_deb;
    logic r_stb;

`ifdef TT_INPUT_DEBOUNCE_EN

    localparam int               c_CW      = f_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0]  c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

    // Counts consecutive edges on which the synchronized input disagrees
    // with the debounced value. It clears on agreement or on acceptance,
    // so it never exceeds c_CNT_MAX and cannot wrap.
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_stb   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_stb   <= 1'b0;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
                r_stb <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`else

    // Without a debouncer the count parameter only serves as a sanity
    // check: an out-of-range value silences the strobe so the
    // misconfiguration is obvious rather than silently ignored.
    localparam bit c_N_LEGAL = (DEBOUNCE_CYCLES >= c_DEBOUNCE_MIN) &&
                               (DEBOUNCE_CYCLES <= c_DEBOUNCE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_deb   <= r_sync2;
            // Strobe lands in the same cycle the new value appears on r_deb.
            r_stb   <= (r_sync2 ^ r_deb) & c_N_LEGAL;
        end
    end

`endif

    assign o_deb = r_deb;
    assign o_stb = r_stb;

endmodule : tt_ecp5_debounce_bit
`default_nettype wire

// File: rtl/tt_ecp5_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : tt_ecp5_input_cond
// Description : Conditions raw ECP5 board inputs for a TT design:
//               per-bit synchronize + debounce of pin_in into ui_in with a
//               change strobe, and synchronize + stretch of the reset button
//               into a clean active-low rst_n.
//               Macro TT_INPUT_DEBOUNCE_EN enables the per-bit debouncer;
//               when undefined ui_in follows the synchronized pins directly.
//   clk, rst : clock and synchronous active-high block reset
//   bus      : tt_ecp5_input_cond_if.slave
//              (pin_in, btn_rst_n in; ui_in, rst_n, change_stb out)
// Revision    : 1.0 - initial release
// ============================================================================
module tt_ecp5_input_cond
    import tt_ecp5_pkg::*;
#(
    parameter int WIDTH           = c_DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int RST_STRETCH     = c_DEF_RST_STRETCH
) (
    input  logic                  clk,
    input  logic                  rst,
    tt_ecp5_input_cond_if.slave   bus
);

    // ------------------------------------------------------------------
    // Per-bit synchronizer + debouncer
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_ui;
    logic [WIDTH-1:0] w_stb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tt_ecp5_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .i_pin (bus.pin_in[i]),
            .o_deb (w_ui[i]),
            .o_stb (w_stb[i])
        );
    end

    assign bus.ui_in      = w_ui;
    assign bus.change_stb = w_stb;

    // ------------------------------------------------------------------
    // Reset button synchronizer and stretcher
    // ------------------------------------------------------------------
    localparam int              c_SW   = f_cnt_width(RST_STRETCH + 1);
    localparam logic [c_SW-1:0] c_SMAX = c_SW'(RST_STRETCH);

    // The synchronizer flops reset to 0 so the button reads as pressed
    // until two clean samples of the released button have been taken.
    logic            r_btn_sync1;
    logic            r_btn_sync2;
    logic [c_SW-1:0] r_scnt;
    logic            r_rst_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_sync1 <= 1'b0;
            r_btn_sync2 <= 1'b0;
            r_scnt      <= '0;
            r_rst_n     <= 1'b0;
        end else begin
            r_btn_sync1 <= bus.btn_rst_n;
            r_btn_sync2 <= r_btn_sync1;
            if (!r_btn_sync2) begin
                // Button held (or re-pressed): restart the stretch.
                r_scnt  <= '0;
                r_rst_n <= 1'b0;
            end else if (r_scnt == c_SMAX) begin
                r_rst_n <= 1'b1;
            end else begin
                r_scnt  <= r_scnt + 1'b1;
                r_rst_n <= 1'b0;
            end
        end
    end

    assign bus.rst_n = r_rst_n;

endmodule : tt_ecp5_input_cond
`default_nettype wire

// File: tb/tb_tt_ecp5_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_ecp5_input_cond
// Description : Self-checking bench for tt_ecp5_input_cond with WIDTH=8,
//               DEBOUNCE_CYCLES=4, RST_STRETCH=16. Expected strobe events
//               (cycle, change_stb, ui_in) are queued by the stimulus and
//               popped by a monitor whenever change_stb is non-zero.
//               Works for both settings of TT_INPUT_DEBOUNCE_EN.
//               Cycle numbering: cyc = index of the last rising edge; a pin
//               driven after edge k-1 is first sampled at edge k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_ecp5_input_cond;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 16;
`ifdef TT_INPUT_DEBOUNCE_EN
    // Sampled at k, sync2 at k+1, N mismatching edges k+2..k+1+N.
    localparam int LAT = N + 1;
`else
    // Sampled at k, sync2 at k+1, deb at k+2.
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        int         ecyc;
        logic [7:0] stb;
        logic [7:0] ui;
    } exp_t;

    exp_t sb[$];

    tt_ecp5_input_cond_if #(.WIDTH(W)) intf ();

    tt_ecp5_input_cond #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N),
        .RST_STRETCH     (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] s, input logic [7:0] u);
        exp_t e;
        e.ecyc = c;
        e.stb  = s;
        e.ui   = u;
        sb.push_back(e);
    endtask

    // Monitor: every non-zero strobe must match the next queued event.
    always @(negedge clk) begin
        if (intf.change_stb !== 8'h00) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe @cyc %0d: stb=0x%0h ui=0x%0h, expected no strobe",
                         cyc, intf.change_stb, intf.ui_in);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc != e.ecyc || intf.change_stb !== e.stb || intf.ui_in !== e.ui) begin
                    n_fail++;
                    $display("FAIL strobe_event: got cyc=%0d stb=0x%0h ui=0x%0h, expected cyc=%0d stb=0x%0h ui=0x%0h",
                             cyc, intf.change_stb, intf.ui_in, e.ecyc, e.stb, e.ui);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        intf.pin_in    = 8'h00;
        intf.btn_rst_n = 1'b1;

        // ---------------- reset state ----------------
        goto(3);
        chk("reset_ui", intf.ui_in, 8'h00);
        chk("reset_stb", intf.change_stb, 8'h00);
        chk("reset_rst_n", intf.rst_n, 1'b0);
        rst = 1'b0;                      // first edge with rst low: 4

        // ---------------- stretch, uninterrupted ----------------
        // btn sync2 high after edge 5, scnt=1 at 6 .. 16 at 21, rst_n at 22.
        goto(21);
        chk("stretch_low", intf.rst_n, 1'b0);
        goto(22);
        chk("stretch_rise", intf.rst_n, 1'b1);

        // ---------------- stretch with re-press ----------------
        rst = 1'b1;                      // sampled at 23, 24
        goto(24);
        chk("rerst_rst_n", intf.rst_n, 1'b0);
        rst = 1'b0;                      // first edge with rst low: 25
        goto(32);
        intf.btn_rst_n = 1'b0;           // sampled low at 33, 34
        goto(34);
        intf.btn_rst_n = 1'b1;
        // sync2 low seen at edges 35, 36; scnt=1 at 37 .. 16 at 52; rise 53.
        goto(43);
        chk("repress_no_early_rise", intf.rst_n, 1'b0);
        goto(52);
        chk("repress_low", intf.rst_n, 1'b0);
        goto(53);
        chk("repress_rise", intf.rst_n, 1'b1);

        // ---------------- single bit 0->1 ----------------
        goto(59);
        intf.pin_in = 8'h01;
        push(60 + LAT, 8'h01, 8'h01);
        goto(60 + LAT - 1);
        chk("bit0_before", intf.ui_in, 8'h00);
        goto(60 + LAT);
        chk("bit0_after", intf.ui_in, 8'h01);

        // ---------------- 3-cycle glitch on bit 3 ----------------
        goto(74);
        intf.pin_in = 8'h09;             // high at edges 75, 76, 77
`ifndef TT_INPUT_DEBOUNCE_EN
        push(77, 8'h08, 8'h09);
        push(80, 8'h08, 8'h01);
`endif
        goto(77);
        intf.pin_in = 8'h01;
        goto(85);
        chk("glitch_ui", intf.ui_in, 8'h01);

        // ---------------- 0x00 -> 0xA5 ----------------
        goto(89);
        intf.pin_in = 8'h00;
        push(90 + LAT, 8'h01, 8'h00);
        goto(104);
        intf.pin_in = 8'hA5;
        push(105 + LAT, 8'hA5, 8'hA5);
        goto(105 + LAT - 1);
        chk("multi_before", intf.ui_in, 8'h00);
        goto(105 + LAT);
        chk("multi_after", intf.ui_in, 8'hA5);

        // ---------------- bit 1 toggles ----------------
        goto(119);
        intf.pin_in = 8'hA7;
        push(120 + LAT, 8'h02, 8'hA7);
        goto(120 + LAT);
        chk("bit1_rise", intf.ui_in, 8'hA7);
        goto(134);
        intf.pin_in = 8'hA5;
        push(135 + LAT, 8'h02, 8'hA5);
        goto(149);
        intf.pin_in = 8'h00;
        push(150 + LAT, 8'hA5, 8'h00);

        // ---------------- rst during debounce (cnt=2) ----------------
        goto(164);
        intf.pin_in = 8'h20;             // sampled at 165
`ifndef TT_INPUT_DEBOUNCE_EN
        push(167, 8'h20, 8'h20);
`endif
        goto(168);
        rst = 1'b1;                      // sampled at 169, cnt=2 then
        goto(169);
        chk("midrst_ui", intf.ui_in, 8'h00);
        chk("midrst_stb", intf.change_stb, 8'h00);
        chk("midrst_rst_n", intf.rst_n, 1'b0);
        rst = 1'b0;                      // debounce restarts from edge 170
        push(170 + LAT, 8'h20, 8'h20);
        goto(170 + LAT - 1);
        chk("midrst_restart_before", intf.ui_in, 8'h00);
        goto(170 + LAT);
        chk("midrst_restart_after", intf.ui_in, 8'h20);
        goto(187);
        chk("midrst_stretch_low", intf.rst_n, 1'b0);
        goto(188);
        chk("midrst_stretch_rise", intf.rst_n, 1'b1);

        goto(195);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tt_ecp5_input_cond
`default_nettype wire

// File: doc/tt_ecp5_input_cond.md
TT_ECP5_INPUT_COND -- requirements
Module: tt_ecp5_input_cond

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the number of board input pins conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES (N), default 50000, the stable cycles required before a debounced bit changes; legal range 2..2^20.
REQ-003 SHALL have parameter RST_STRETCH (S), default 16, the cycles rst_n is held low after all reset sources release; legal range 1..256.
REQ-004 SHALL have port clk, input, 1, the single clock for the block.
REQ-005 SHALL have port rst, input, 1, the block reset; one clock, and reset is synchronous and active-high.
REQ-006 SHALL have port pin_in, input, WIDTH, raw asynchronous board switches/buttons.
REQ-007 SHALL have port btn_rst_n, input, 1, raw asynchronous board reset button, active-low.
REQ-008 SHALL have port ui_in, output, WIDTH, conditioned inputs to the TT design.
REQ-009 SHALL have port rst_n, output, 1, stretched active-low reset to the TT design.
REQ-010 SHALL have port change_stb, output, WIDTH, a one-cycle pulse per bit when ui_in[i] changes.

Function
REQ-011 SHALL pass each pin_in bit and btn_rst_n through a two-flop synchronizer (sync1, sync2).
REQ-012 SHALL keep per bit a counter cnt and a debounced value deb, with ui_in[i] = deb[i] (registered).
REQ-013 SHALL reset cnt to 0 on any edge where sync2[i] == deb[i].
REQ-014 SHALL, on an edge where sync2[i] != deb[i] and cnt < N-1, increment cnt.
REQ-015 SHALL, on an edge where sync2[i] != deb[i] and cnt == N-1, load deb[i] <= sync2[i], clear cnt, and assert change_stb[i] for exactly that following cycle.
REQ-016 SHALL therefore latch a raw change first sampled at edge k so that ui_in updates after edge k+1+N, provided the pin stays stable throughout.
REQ-017 SHALL discard a glitch shorter than N cycles at sync2: cnt returns to 0, with no ui_in change and no strobe.
REQ-018 SHALL treat bits independently, so simultaneous changes on several bits each strobe on their own qualifying edge.
REQ-019 SHALL size cnt to clog2(N) bits, with no wrap-around possible because cnt saturates at N-1 and then clears.
REQ-020 SHALL hold the stretch counter scnt at 0 and drive rst_n = 0 while rst = 1 or btn sync2 = 0.
REQ-021 SHALL, otherwise, increment scnt each cycle until it reaches S, then drive rst_n = 1 and hold scnt at S.
REQ-022 SHALL register rst_n, which rises on the edge after scnt reaches S.
REQ-023 SHALL, if btn_rst_n is re-pressed mid-stretch, clear scnt and restart the stretch.

Reset
REQ-024 SHALL, on rst, set sync flops of pin_in to 0, btn sync flops to 0 (reset asserted), deb 0, cnt 0, scnt 0, ui_in 0, change_stb 0, rst_n 0.
REQ-025 SHALL make rst take effect on the next clk edge and discard any debounce in progress.

Configuration
REQ-026 SHALL honour macro TT_INPUT_DEBOUNCE_EN: when defined, debounce operates per REQ-012..REQ-019.
REQ-027 SHALL, when TT_INPUT_DEBOUNCE_EN is undefined, omit cnt entirely, set deb[i] <= sync2[i] every cycle (ui_in latency 3 edges from raw change), and pulse change_stb[i] whenever deb[i] changes; the reset stretch is unaffected.

Structure
REQ-028 SHALL place default WIDTH, DEBOUNCE_CYCLES and RST_STRETCH constants in shared package tt_ecp5_pkg.
REQ-029 SHALL implement the per-bit synchronizer plus debounce as sub-module tt_ecp5_debounce_bit, instantiated WIDTH times; the btn_rst_n synchronizer and stretch logic live in the top module.

Verification
REQ-030 SHALL cover: N=4, pin_in[0] 0->1 at edge k and held -> ui_in[0]=1 after edge k+5, change_stb[0]=1 for exactly one cycle, other bits unchanged.
REQ-031 SHALL cover: N=4, pin_in[3] high for 3 cycles then low -> ui_in[3] stays 0, change_stb stays 0.
REQ-032 SHALL cover: N=4, pin_in 0x00->0xA5 in one cycle -> ui_in=0xA5 after edge k+5, change_stb=0xA5 for one cycle.
REQ-033 SHALL cover: S=16, rst released with btn_rst_n=1 -> rst_n rises 16-18 cycles later; btn_rst_n pulsed low at cycle 8 -> stretch restarts from 0.
REQ-034 SHALL cover: rst asserted during debounce at cnt=2 -> next edge ui_in=0, cnt=0, rst_n=0, change_stb=0.
REQ-035 SHALL cover: build without TT_INPUT_DEBOUNCE_EN, pin_in[1] toggles at edge k -> ui_in[1] follows after edge k+2, one-cycle strobe.
